// File: rtl/axi_pkg.sv
// Shared AXI definitions: bus widths, response codes and burst encodings.
package axi_pkg;

   localparam int unsigned ID_W   = 8;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_sram_slave.sv
// Single-outstanding AXI slave bridging INCR bursts onto a single-port SRAM macro
// with active-low strobes and one-cycle read latency.
module axi_sram_slave
   import axi_pkg::*;
#(
   parameter int unsigned SRAM_AW = 14
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [ID_W-1:0]   ARID,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic [3:0]        ARLEN,
   input  logic [2:0]        ARSIZE,
   input  logic [1:0]        ARBURST,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [ID_W-1:0]   RID,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP,
   output logic              RLAST,
   output logic              RVALID,
   input  logic              RREADY,
   input  logic [ID_W-1:0]   AWID,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic [3:0]        AWLEN,
   input  logic [2:0]        AWSIZE,
   input  logic [1:0]        AWBURST,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [DATA_W-1:0] WDATA,
   input  logic [STRB_W-1:0] WSTRB,
   input  logic              WLAST,
   input  logic              WVALID,
   output logic              WREADY,
   output logic [ID_W-1:0]   BID,
   output logic [1:0]        BRESP,
   output logic              BVALID,
   input  logic              BREADY,
   output logic              CEB,
   output logic              WEB,
   output logic [DATA_W-1:0] BWEB,
   output logic [SRAM_AW-1:0] A,
   output logic [DATA_W-1:0] DI,
   input  logic [DATA_W-1:0] DO
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;

   state_t               state;
   logic                 last_wr;
   logic [3:0]           len;
   logic [SRAM_AW-1:0]   addr;
   logic [4:0]           cnt;
   logic [3:0]           load_cnt;
   logic                 pend;
   logic                 skid_v;
   logic [DATA_W-1:0]    skid;

   logic                 tie;
   logic                 ar_go;
   logic                 aw_go;
   logic                 consume;
   logic [1:0]           occ;
   logic                 rd_issue;
   logic                 wr_beat;
   logic                 wr_end;
   logic                 unused_in;

   // Burst type and size are ignored: every burst is a 32-bit INCR burst.
   assign unused_in = ^{ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0], ARSIZE, ARBURST,
                        AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0], AWSIZE, AWBURST};

   // Handshake arbitration and the SRAM strobes are combinational on the current beat.
   always_comb begin
      tie      = ARVALID && AWVALID;
      ARREADY  = (state == IDLE) && !(tie && !last_wr);
      AWREADY  = (state == IDLE) && !(tie && last_wr);
      ar_go    = ARVALID && ARREADY;
      aw_go    = AWVALID && AWREADY;
      consume  = RVALID && RREADY;
      // Words committed to the output path: holding reg, skid and one in flight.
      occ      = 2'(RVALID) + 2'(skid_v) + 2'(pend);
      rd_issue = (state == READ) && (cnt <= {1'b0, len}) && ((occ - 2'(consume)) < 2'd2);
      wr_beat  = (state == WRITE) && WVALID && WREADY;
      wr_end   = wr_beat && (WLAST || (cnt == {1'b0, len}));
      CEB      = !(rd_issue || wr_beat);
      WEB      = !wr_beat;
      A        = addr;
      DI       = WDATA;
      BWEB     = '1;
      if (wr_beat) begin
         for (int k = 0; k < int'(STRB_W); k++) begin
            BWEB[8*k +: 8] = {8{~WSTRB[k]}};
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state    <= IDLE;
         last_wr  <= 1'b0;
         len      <= '0;
         addr     <= '0;
         cnt      <= '0;
         load_cnt <= '0;
         pend     <= 1'b0;
         skid_v   <= 1'b0;
         skid     <= '0;
         RID      <= '0;
         RDATA    <= '0;
         RRESP    <= RESP_OKAY;
         RLAST    <= 1'b0;
         RVALID   <= 1'b0;
         WREADY   <= 1'b0;
         BID      <= '0;
         BRESP    <= RESP_OKAY;
         BVALID   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt      <= '0;
               load_cnt <= '0;
               pend     <= 1'b0;
               skid_v   <= 1'b0;
               if (aw_go) begin
                  BID     <= AWID;
                  addr    <= AWADDR[SRAM_AW+1:2];
                  len     <= AWLEN;
                  last_wr <= 1'b1;
                  WREADY  <= 1'b1;
                  state   <= WRITE;
               end else if (ar_go) begin
                  RID     <= ARID;
                  addr    <= ARADDR[SRAM_AW+1:2];
                  len     <= ARLEN;
                  last_wr <= 1'b0;
                  state   <= READ;
               end
            end
            READ: begin
               pend <= rd_issue;
               if (rd_issue) begin
                  addr <= addr + SRAM_AW'(1);
                  cnt  <= cnt + 5'd1;
               end
               // The skid holds a word that lands while the output register is stalled.
               if (!RVALID || consume) begin
                  if (skid_v || pend) begin
                     RDATA    <= skid_v ? skid : DO;
                     RRESP    <= RESP_OKAY;
                     RVALID   <= 1'b1;
                     RLAST    <= (load_cnt == len);
                     load_cnt <= load_cnt + 4'd1;
                     skid_v   <= skid_v && pend;
                     if (skid_v && pend) begin
                        skid <= DO;
                     end
                  end else begin
                     RVALID <= 1'b0;
                  end
               end else if (pend) begin
                  skid   <= DO;
                  skid_v <= 1'b1;
               end
               if (consume && RLAST) begin
                  RVALID <= 1'b0;
                  RLAST  <= 1'b0;
                  pend   <= 1'b0;
                  skid_v <= 1'b0;
                  state  <= IDLE;
               end
            end
            WRITE: begin
               if (wr_beat) begin
                  addr <= addr + SRAM_AW'(1);
                  cnt  <= cnt + 5'd1;
               end
               if (wr_end) begin
                  BRESP  <= (WLAST && (cnt == {1'b0, len})) ? RESP_OKAY : RESP_SLVERR;
                  WREADY <= 1'b0;
                  BVALID <= 1'b1;
                  state  <= WRESP;
               end
            end
            WRESP: begin
               if (BREADY) begin
                  BVALID <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
